// File: rtl/bsg_fifo_1r1w_circ_tracker_if.sv
// ============================================================================
// Module  : bsg_fifo_1r1w_circ_tracker_if
// Brief   : Producer/consumer handshake bundle for the circular-pointer FIFO.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bsg_fifo_1r1w_circ_tracker_if #(
  parameter int width_p = 8,
  parameter int els_p   = 16
);
  localparam int ptr_width_lp = $clog2(els_p);

  logic                  v_i;
  logic [width_p-1:0]    data_i;
  logic                  ready_o;
  logic                  v_o;
  logic [width_p-1:0]    data_o;
  logic                  yumi_i;
  logic [ptr_width_lp:0] count_o;

  modport master (
    output v_i, data_i, yumi_i,
    input  ready_o, v_o, data_o, count_o
  );

  modport slave (
    input  v_i, data_i, yumi_i,
    output ready_o, v_o, data_o, count_o
  );
endinterface

`default_nettype wire

// File: rtl/bsg_fifo_1r1w_circ_tracker.sv
// ============================================================================
// Module  : bsg_fifo_1r1w_circ_tracker
// Brief   : 1R1W show-ahead FIFO tracked by two circular pointers plus wrap bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bsg_fifo_1r1w_circ_tracker #(
  parameter int width_p = 8,
  parameter int els_p   = 16
) (
  input  wire logic                    clk,
  input  wire logic                    reset_n_i,
  bsg_fifo_1r1w_circ_tracker_if.slave  fifo
);
  localparam int ptr_width_lp = $clog2(els_p);

  if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_els_check
    $error("els_p must be a power of two >= 2");
  end

  logic [ptr_width_lp-1:0] r_wptr;
  logic [ptr_width_lp-1:0] r_rptr;
  logic                    r_wwrap;
  logic                    r_rwrap;
  logic [width_p-1:0]      r_mem [els_p];

  logic                    w_ptr_eq;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_enq;
  logic                    w_deq;
  logic [ptr_width_lp:0]   w_count;

  // Equal pointers mean empty or full; the wrap bits disambiguate.
  assign w_ptr_eq = (r_wptr == r_rptr);
  assign w_empty  = w_ptr_eq && (r_wwrap == r_rwrap);
  assign w_full   = w_ptr_eq && (r_wwrap != r_rwrap);
  assign w_count  = {r_wwrap, r_wptr} - {r_rwrap, r_rptr};

  assign fifo.ready_o = reset_n_i && !w_full;
  assign fifo.v_o     = reset_n_i && !w_empty;
  assign fifo.data_o  = r_mem[r_rptr];
  assign fifo.count_o = reset_n_i ? w_count : '0;

  assign w_enq = fifo.v_i && fifo.ready_o;
  assign w_deq = fifo.yumi_i && fifo.v_o;

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      r_wptr  <= '0;
      r_wwrap <= 1'b0;
      r_rptr  <= '0;
      r_rwrap <= 1'b0;
    end else begin
      if (w_enq) begin
        {r_wwrap, r_wptr} <= {r_wwrap, r_wptr} + (ptr_width_lp+1)'(1);
      end
      if (w_deq) begin
        {r_rwrap, r_rptr} <= {r_rwrap, r_rptr} + (ptr_width_lp+1)'(1);
      end
    end
  end

  // Storage is intentionally left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wptr] <= fifo.data_i;
    end
  end

  a_yumi_when_empty: assert property (
    @(posedge clk) disable iff (!reset_n_i) !(fifo.yumi_i && !fifo.v_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_bsg_fifo_1r1w_circ_tracker.sv
// ============================================================================
// Module  : tb_bsg_fifo_1r1w_circ_tracker
// Brief   : Randomized and directed bench against a queue-based FIFO model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bsg_fifo_1r1w_circ_tracker;
  localparam int WIDTH = 8;
  localparam int ELS   = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [WIDTH-1:0] q[$];

  always #5 clk = ~clk;

  bsg_fifo_1r1w_circ_tracker_if #(.width_p(WIDTH), .els_p(ELS)) fifo ();

  bsg_fifo_1r1w_circ_tracker #(.width_p(WIDTH), .els_p(ELS)) dut (
    .clk       (clk),
    .reset_n_i (reset_n),
    .fifo      (fifo)
  );

  // One clock: apply inputs, advance the model on the edge, settle 1 time unit.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic y);
    bit enq, deq;
    fifo.v_i = v; fifo.data_i = d; fifo.yumi_i = y;
    @(posedge clk);
    if (!reset_n) q.delete();
    else begin
      enq = v && (q.size() < ELS);
      deq = y && (q.size() > 0);
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    n_checks++;
    if (fifo.ready_o !== 1'b0 || fifo.v_o !== 1'b0 || fifo.count_o !== 5'd0)
      $display("FAIL reset_hold ready=%b v=%b count=%0d required 0/0/0", fifo.ready_o, fifo.v_o, fifo.count_o);
    else n_pass++;
    reset_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    n_checks++;
    if (fifo.ready_o !== 1'b1 || fifo.v_o !== 1'b0 || fifo.count_o !== 5'd0)
      $display("FAIL reset_release ready=%b v=%b count=%0d required 1/0/0", fifo.ready_o, fifo.v_o, fifo.count_o);
    else n_pass++;
  endtask

  task automatic test_fill();
    for (int i = 0; i < ELS; i++) begin
      step(1'b1, WIDTH'(i), 1'b0);
      n_checks++;
      if (fifo.count_o !== 5'(i + 1) || fifo.v_o !== 1'b1 || fifo.data_o !== 8'h00)
        $display("FAIL fill_step%0d count=%0d v=%b data=%h required %0d/1/00", i, fifo.count_o, fifo.v_o, fifo.data_o, i + 1);
      else n_pass++;
    end
    n_checks++;
    if (fifo.ready_o !== 1'b0)
      $display("FAIL fill_full_ready ready=%b required 0", fifo.ready_o);
    else n_pass++;
    step(1'b1, 8'hEE, 1'b0);
    n_checks++;
    if (fifo.count_o !== 5'd16 || fifo.data_o !== 8'h00)
      $display("FAIL fill_overflow count=%0d data=%h required 16/00", fifo.count_o, fifo.data_o);
    else n_pass++;
  endtask

  task automatic test_drain_wrap();
    for (int i = 0; i < ELS; i++) begin
      n_checks++;
      if (fifo.v_o !== 1'b1 || fifo.data_o !== WIDTH'(i))
        $display("FAIL drain_data%0d v=%b data=%h required 1/%h", i, fifo.v_o, fifo.data_o, WIDTH'(i));
      else n_pass++;
      step(1'b0, 8'h00, 1'b1);
    end
    n_checks++;
    if (fifo.v_o !== 1'b0 || fifo.count_o !== 5'd0 || fifo.ready_o !== 1'b1)
      $display("FAIL drain_empty v=%b count=%0d ready=%b required 0/0/1", fifo.v_o, fifo.count_o, fifo.ready_o);
    else n_pass++;
    step(1'b1, 8'hA5, 1'b0);
    n_checks++;
    if (fifo.v_o !== 1'b1 || fifo.data_o !== 8'hA5 || fifo.count_o !== 5'd1)
      $display("FAIL wrap_enq v=%b data=%h count=%0d required 1/a5/1", fifo.v_o, fifo.data_o, fifo.count_o);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    while (q.size() < 5) step(1'b1, WIDTH'($urandom), 1'b0);
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (fifo.data_o !== q[0])
        $display("FAIL b2b_data%0d data=%h required %h", i, fifo.data_o, q[0]);
      else n_pass++;
      d = WIDTH'($urandom);
      step(1'b1, d, 1'b1);
      n_checks++;
      if (fifo.count_o !== 5'd5)
        $display("FAIL b2b_count%0d count=%0d required 5", i, fifo.count_o);
      else n_pass++;
    end
  endtask

  task automatic test_full_yumi();
    logic [WIDTH-1:0] d;
    while (q.size() < ELS) step(1'b1, WIDTH'($urandom), 1'b0);
    d = 8'h5C;
    step(1'b1, d, 1'b1);
    n_checks++;
    if (fifo.count_o !== 5'd15 || fifo.ready_o !== 1'b1)
      $display("FAIL full_yumi count=%0d ready=%b required 15/1", fifo.count_o, fifo.ready_o);
    else n_pass++;
    step(1'b1, d, 1'b0);
    n_checks++;
    if (fifo.count_o !== 5'd16 || fifo.ready_o !== 1'b0 || fifo.data_o !== q[0])
      $display("FAIL full_refill count=%0d ready=%b data=%h required 16/0/%h", fifo.count_o, fifo.ready_o, fifo.data_o, q[0]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    while (q.size() > 7) begin
      n_checks++;
      if (fifo.data_o !== q[0])
        $display("FAIL mid_drain data=%h required %h", fifo.data_o, q[0]);
      else n_pass++;
      step(1'b0, 8'h00, 1'b1);
    end
    n_checks++;
    if (fifo.count_o !== 5'd7)
      $display("FAIL mid_count count=%0d required 7", fifo.count_o);
    else n_pass++;
    reset_n = 1'b0;
    step(1'b1, 8'h33, 1'b0);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (fifo.count_o !== 5'd0 || fifo.v_o !== 1'b0 || fifo.ready_o !== 1'b1)
      $display("FAIL mid_reset count=%0d v=%b ready=%b required 0/0/1", fifo.count_o, fifo.v_o, fifo.ready_o);
    else n_pass++;
    step(1'b1, 8'h77, 1'b0);
    n_checks++;
    if (fifo.data_o !== 8'h77 || fifo.count_o !== 5'd1)
      $display("FAIL mid_after data=%h count=%0d required 77/1", fifo.data_o, fifo.count_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic v, y;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 99) < 55);
      y = (q.size() > 0) && ($urandom_range(0, 99) < 50);
      reset_n = ($urandom_range(0, 99) != 0);
      step(v, WIDTH'($urandom), y);
      reset_n = 1'b1;
      #1;
      n_checks++;
      if (fifo.count_o !== 5'(q.size()) || fifo.v_o !== (q.size() > 0) ||
          fifo.ready_o !== (q.size() < ELS) || (q.size() > 0 && fifo.data_o !== q[0]))
        $display("FAIL rand%0d count=%0d v=%b ready=%b data=%h required count=%0d head=%h",
                 i, fifo.count_o, fifo.v_o, fifo.ready_o, fifo.data_o, q.size(),
                 (q.size() > 0) ? q[0] : 8'h00);
      else n_pass++;
    end
  endtask

  initial begin
    fifo.v_i = 1'b0; fifo.data_i = '0; fifo.yumi_i = 1'b0;
    test_reset();
    test_fill();
    test_drain_wrap();
    test_back_to_back();
    test_full_yumi();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
